hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RISC-V core (q1 fetch, q2 decode, q3 execute, q4 memory, q5 writeback). It detects load-use hazards, selects q3 operand forwarding, and redirects fetch on taken branches. It also stalls the pipeline on data-memory wait states with a timeout fault, and keeps saturating stall/flush performance counters. It drives the write-enable and flush inputs of the PC register and the q1q2/q2q3/q3q4 pipeline registers.

---
 rtl/hazard_ctrl_pkg.sv | 34 +++
 rtl/hazard_ctrl_fwd_unit.sv | 40 ++++
 rtl/hazard_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: hazard FSM
// state encodings, forwarding-select encodings, control-word bit indices
// shared with the control unit and the core, and a small compare helper.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FAULT    = 2'd3
  } hz_state_e;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REG = 2'b00;
  localparam fwd_sel_t FWD_Q4  = 2'b10;
  localparam fwd_sel_t FWD_Q5  = 2'b01;

  // Control-word bit positions carried through the pipeline registers.
  localparam int CTRL_REG_WE = 0;
  localparam int CTRL_MEM_RE = 1;
  localparam int CTRL_MEM_WE = 2;
  localparam int CTRL_BRANCH = 3;
  localparam int CTRL_JUMP   = 4;
  localparam int CTRL_W      = 5;

  // True when a later stage writes a non-x0 register that the source reads.
  function automatic logic src_match(input logic       we,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding compare logic for both q3 operands. Purely combinational;
// the nearer stage (q4) wins over q5 when both hold the same register.
module hazard_ctrl_fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] q4_rd,
  input  logic       q4_we,
  input  logic [4:0] q5_rd,
  input  logic       q5_we,
  output fwd_sel_t   fwd_a,
  output fwd_sel_t   fwd_b
);

  // Select operand A source: q4 result first, then q5 writeback, else regfile.
  always_comb begin
    fwd_a = FWD_REG;
    if (src_match(q4_we, q4_rd, rs1)) begin
      fwd_a = FWD_Q4;
    end else if (src_match(q5_we, q5_rd, rs1)) begin
      fwd_a = FWD_Q5;
    end else begin
      fwd_a = FWD_REG;
    end
  end

  // Select operand B source with the same precedence as operand A.
  always_comb begin
    fwd_b = FWD_REG;
    if (src_match(q4_we, q4_rd, rs2)) begin
      fwd_b = FWD_Q4;
    end else if (src_match(q5_we, q5_rd, rs2)) begin
      fwd_b = FWD_Q5;
    end else begin
      fwd_b = FWD_REG;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: load-use stall,
// q3 operand forwarding, taken-branch redirect with fetch-latency flush,
// data-memory wait freeze with timeout fault, and saturating perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FETCH_LATENCY = 1,
  parameter int MEM_TIMEOUT   = 255,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       q2_rs1_i,
  input  logic [4:0]       q2_rs2_i,
  input  logic [4:0]       q3_rs1_i,
  input  logic [4:0]       q3_rs2_i,
  input  logic [4:0]       q3_rd_i,
  input  logic             q3_mem_re_i,
  input  logic [4:0]       q4_rd_i,
  input  logic             q4_reg_we_i,
  input  logic [4:0]       q5_rd_i,
  input  logic             q5_reg_we_i,
  input  logic             q4_branch_taken_i,
  input  logic             mem_busy_i,
  output logic             pc_we_o,
  output logic             pc_sel_o,
  output logic             q1q2_we_o,
  output logic             q1q2_flush_o,
  output logic             q2q3_flush_o,
  output logic             q3q4_flush_o,
  output logic             pipe_stall_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int                WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
  localparam logic [2:0]        FETCH_LAT = 3'(FETCH_LATENCY);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  hz_state_e         state_r;
  hz_state_e         state_nxt_s;
  hz_state_e         eff_state_s;
  logic [2:0]        redir_cnt_r;
  logic [2:0]        redir_cnt_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_nxt_s;
  logic              mem_err_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;
  logic              stall_evt_s;
  logic              flush_evt_s;
  logic              load_use_s;

  logic              pc_we_s;
  logic              pc_sel_s;
  logic              q1q2_we_s;
  logic              q1q2_flush_s;
  logic              q2q3_flush_s;
  logic              q3q4_flush_s;
  logic              pipe_stall_s;
  fwd_sel_t          fwd_a_s;
  fwd_sel_t          fwd_b_s;

  hazard_ctrl_fwd_unit u_fwd_unit (
    .rs1   (q3_rs1_i),
    .rs2   (q3_rs2_i),
    .q4_rd (q4_rd_i),
    .q4_we (q4_reg_we_i),
    .q5_rd (q5_rd_i),
    .q5_we (q5_reg_we_i),
    .fwd_a (fwd_a_s),
    .fwd_b (fwd_b_s)
  );

  // Hazard resolution: next state, counter updates and pipeline controls.
  always_comb begin
    state_nxt_s     = state_r;
    redir_cnt_nxt_s = redir_cnt_r;
    wait_cnt_nxt_s  = wait_cnt_r;
    stall_evt_s     = 1'b0;
    flush_evt_s     = 1'b0;
    pc_we_s         = 1'b1;
    pc_sel_s        = 1'b0;
    q1q2_we_s       = 1'b1;
    q1q2_flush_s    = 1'b0;
    q2q3_flush_s    = 1'b0;
    q3q4_flush_s    = 1'b0;
    pipe_stall_s    = 1'b0;

    // Leaving a memory wait resumes whatever redirect was in progress.
    if (state_r == ST_MEM_WAIT) begin
      eff_state_s = (redir_cnt_r != 3'd0) ? ST_REDIRECT : ST_RUN;
    end else begin
      eff_state_s = state_r;
    end

    load_use_s = q3_mem_re_i && (q3_rd_i != 5'd0) &&
                 ((q3_rd_i == q2_rs1_i) || (q3_rd_i == q2_rs2_i));

    if (state_r == ST_FAULT) begin
      pc_we_s      = 1'b0;
      q1q2_we_s    = 1'b0;
      pipe_stall_s = 1'b1;
    end else if (mem_busy_i) begin
      pc_we_s      = 1'b0;
      q1q2_we_s    = 1'b0;
      pipe_stall_s = 1'b1;
      stall_evt_s  = 1'b1;
      state_nxt_s  = ST_MEM_WAIT;
      if (wait_cnt_r != WAIT_MAX) begin
        wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
      end else begin
        wait_cnt_nxt_s = wait_cnt_r;
      end
      if ((MEM_TIMEOUT != 0) && (wait_cnt_r == WAIT_LAST)) begin
        state_nxt_s = ST_FAULT;
      end else begin
        state_nxt_s = ST_MEM_WAIT;
      end
    end else if (q4_branch_taken_i) begin
      wait_cnt_nxt_s  = '0;
      pc_sel_s        = 1'b1;
      q1q2_flush_s    = 1'b1;
      q2q3_flush_s    = 1'b1;
      q3q4_flush_s    = 1'b1;
      flush_evt_s     = 1'b1;
      redir_cnt_nxt_s = FETCH_LAT;
      state_nxt_s     = (FETCH_LAT != 3'd0) ? ST_REDIRECT : ST_RUN;
    end else begin
      wait_cnt_nxt_s = '0;
      if (eff_state_s == ST_REDIRECT) begin
        q1q2_flush_s = 1'b1;
        if (redir_cnt_r > 3'd1) begin
          redir_cnt_nxt_s = redir_cnt_r - 3'd1;
          state_nxt_s     = ST_REDIRECT;
        end else begin
          redir_cnt_nxt_s = 3'd0;
          state_nxt_s     = ST_RUN;
        end
      end else begin
        state_nxt_s = ST_RUN;
      end
      if (load_use_s) begin
        pc_we_s      = 1'b0;
        q1q2_we_s    = 1'b0;
        q2q3_flush_s = 1'b1;
        stall_evt_s  = 1'b1;
      end else begin
        stall_evt_s  = 1'b0;
      end
    end
  end

  // Output stage: reset forces a safe bubble-filled pipeline immediately.
  always_comb begin
    if (!rst_n) begin
      pc_we_o      = 1'b0;
      pc_sel_o     = 1'b0;
      q1q2_we_o    = 1'b0;
      q1q2_flush_o = 1'b1;
      q2q3_flush_o = 1'b1;
      q3q4_flush_o = 1'b1;
      pipe_stall_o = 1'b0;
      fwd_a_o      = FWD_REG;
      fwd_b_o      = FWD_REG;
    end else begin
      pc_we_o      = pc_we_s;
      pc_sel_o     = pc_sel_s;
      q1q2_we_o    = q1q2_we_s;
      q1q2_flush_o = q1q2_flush_s;
      q2q3_flush_o = q2q3_flush_s;
      q3q4_flush_o = q3q4_flush_s;
      pipe_stall_o = pipe_stall_s;
      fwd_a_o      = fwd_a_s;
      fwd_b_o      = fwd_b_s;
    end
  end

  // FSM state, redirect/wait counters and the sticky fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_RUN;
      redir_cnt_r <= 3'd0;
      wait_cnt_r  <= '0;
      mem_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      redir_cnt_r <= redir_cnt_nxt_s;
      wait_cnt_r  <= wait_cnt_nxt_s;
      mem_err_r   <= mem_err_r | (state_nxt_s == ST_FAULT);
    end
  end

  // Saturating stall and flush performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (stall_evt_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_evt_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign mem_err_o   = mem_err_r;
  assign stall_cnt_o = stall_cnt_r;
  assign flush_cnt_o = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (FETCH_LATENCY=1, MEM_TIMEOUT=4, CNT_W=4).
// The driver sets inputs just after each rising edge and queues the
// hand-computed expected output vector; the monitor pops and compares on
// every falling edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] q2_rs1, q2_rs2, q3_rs1, q3_rs2, q3_rd, q4_rd, q5_rd;
  logic       q3_mem_re, q4_reg_we, q5_reg_we, br_taken, mem_busy;
  logic       pc_we_o, pc_sel_o, q1q2_we_o, q1q2_flush_o, q2q3_flush_o, q3q4_flush_o;
  logic       pipe_stall_o, mem_err_o;
  logic [1:0] fwd_a_o, fwd_b_o;
  logic [3:0] stall_cnt_o, flush_cnt_o;

  typedef struct {
    string       name;
    logic [19:0] v;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [19:0] mon_act;
  int          checks   = 0;
  int          failures = 0;

  // Control vector order: {pc_we, pc_sel, q1q2_we, q1q2_flush, q2q3_flush, q3q4_flush, pipe_stall}
  localparam logic [6:0] C_NORM = 7'b1010000;
  localparam logic [6:0] C_RST  = 7'b0001110;
  localparam logic [6:0] C_LU   = 7'b0000100;
  localparam logic [6:0] C_BR   = 7'b1111110;
  localparam logic [6:0] C_RDR  = 7'b1011000;
  localparam logic [6:0] C_FRZ  = 7'b0000001;

  always #5 clk = ~clk;

  hazard_ctrl #(.FETCH_LATENCY(1), .MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .q2_rs1_i          (q2_rs1),
    .q2_rs2_i          (q2_rs2),
    .q3_rs1_i          (q3_rs1),
    .q3_rs2_i          (q3_rs2),
    .q3_rd_i           (q3_rd),
    .q3_mem_re_i       (q3_mem_re),
    .q4_rd_i           (q4_rd),
    .q4_reg_we_i       (q4_reg_we),
    .q5_rd_i           (q5_rd),
    .q5_reg_we_i       (q5_reg_we),
    .q4_branch_taken_i (br_taken),
    .mem_busy_i        (mem_busy),
    .pc_we_o           (pc_we_o),
    .pc_sel_o          (pc_sel_o),
    .q1q2_we_o         (q1q2_we_o),
    .q1q2_flush_o      (q1q2_flush_o),
    .q2q3_flush_o      (q2q3_flush_o),
    .q3q4_flush_o      (q3q4_flush_o),
    .pipe_stall_o      (pipe_stall_o),
    .fwd_a_o           (fwd_a_o),
    .fwd_b_o           (fwd_b_o),
    .mem_err_o         (mem_err_o),
    .stall_cnt_o       (stall_cnt_o),
    .flush_cnt_o       (flush_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    q2_rs1 = 5'd0; q2_rs2 = 5'd0; q3_rs1 = 5'd0; q3_rs2 = 5'd0; q3_rd = 5'd0;
    q4_rd = 5'd0; q5_rd = 5'd0; q3_mem_re = 1'b0; q4_reg_we = 1'b0;
    q5_reg_we = 1'b0; br_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic expect_v(input string nm, input logic [6:0] c, input logic [1:0] fa,
                          input logic [1:0] fb, input logic err, input logic [3:0] sc,
                          input logic [3:0] fc);
    exp_t e;
    e.name = nm;
    e.v    = {c, fa, fb, err, sc, fc};
    sb_q.push_back(e);
  endtask

  // Monitor: compare the DUT outputs against the queued expectation each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_e   = sb_q.pop_front();
        mon_act = {pc_we_o, pc_sel_o, q1q2_we_o, q1q2_flush_o, q2q3_flush_o, q3q4_flush_o,
                   pipe_stall_o, fwd_a_o, fwd_b_o, mem_err_o, stall_cnt_o, flush_cnt_o};
        checks++;
        if (mon_act !== mon_e.v) begin
          failures++;
          $display("FAIL %s: got ctl=%b fa=%b fb=%b err=%b stall=%0d flush=%0d, expected ctl=%b fa=%b fb=%b err=%b stall=%0d flush=%0d",
                   mon_e.name, mon_act[19:13], mon_act[12:11], mon_act[10:9], mon_act[8],
                   mon_act[7:4], mon_act[3:0], mon_e.v[19:13], mon_e.v[12:11], mon_e.v[10:9],
                   mon_e.v[8], mon_e.v[7:4], mon_e.v[3:0]);
        end
      end
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    rst_n = 1'b0;
    idle();
    tick(); expect_v("reset", C_RST, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0);
    tick(); rst_n = 1'b1; expect_v("idle", C_NORM, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0);

    // Load-use on rs1, bubble, then q5 forwarding.
    tick(); q3_mem_re = 1'b1; q3_rd = 5'd5; q2_rs1 = 5'd5;
    expect_v("lu_stall", C_LU, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0);
    tick(); q3_mem_re = 1'b0; q3_rd = 5'd0; q4_rd = 5'd5; q4_reg_we = 1'b1;
    expect_v("lu_bubble", C_NORM, 2'b00, 2'b00, 1'b0, 4'd1, 4'd0);
    tick(); q2_rs1 = 5'd0; q3_rs1 = 5'd5; q4_rd = 5'd0; q4_reg_we = 1'b0;
    q5_rd = 5'd5; q5_reg_we = 1'b1;
    expect_v("lu_fwd_q5", C_NORM, 2'b01, 2'b00, 1'b0, 4'd1, 4'd0);

    // Forwarding priority and x0 exclusion.
    tick(); idle(); q3_rs1 = 5'd3; q3_rs2 = 5'd7; q4_rd = 5'd7; q4_reg_we = 1'b1;
    q5_rd = 5'd7; q5_reg_we = 1'b1;
    expect_v("fwd_b_q4", C_NORM, 2'b00, 2'b10, 1'b0, 4'd1, 4'd0);
    tick(); q3_rs2 = 5'd0; q4_rd = 5'd0; q5_rd = 5'd0;
    expect_v("fwd_b_x0", C_NORM, 2'b00, 2'b00, 1'b0, 4'd1, 4'd0);
    tick(); q3_rs1 = 5'd7; q3_rs2 = 5'd7; q4_rd = 5'd7; q4_reg_we = 1'b0; q5_rd = 5'd7;
    expect_v("fwd_q5_only", C_NORM, 2'b01, 2'b01, 1'b0, 4'd1, 4'd0);

    // Taken branch with one cycle of fetch latency.
    tick(); idle(); br_taken = 1'b1;
    expect_v("br_c0", C_BR, 2'b00, 2'b00, 1'b0, 4'd1, 4'd0);
    tick(); br_taken = 1'b0;
    expect_v("br_c1", C_RDR, 2'b00, 2'b00, 1'b0, 4'd1, 4'd1);
    tick(); expect_v("br_c2", C_NORM, 2'b00, 2'b00, 1'b0, 4'd1, 4'd1);

    // Memory wait holding off a branch in q4.
    tick(); mem_busy = 1'b1; br_taken = 1'b1;
    expect_v("mw1", C_FRZ, 2'b00, 2'b00, 1'b0, 4'd1, 4'd1);
    tick(); expect_v("mw2", C_FRZ, 2'b00, 2'b00, 1'b0, 4'd2, 4'd1);
    tick(); expect_v("mw3", C_FRZ, 2'b00, 2'b00, 1'b0, 4'd3, 4'd1);
    tick(); mem_busy = 1'b0;
    expect_v("mw_redirect", C_BR, 2'b00, 2'b00, 1'b0, 4'd4, 4'd1);
    tick(); br_taken = 1'b0;
    expect_v("mw_redir_c1", C_RDR, 2'b00, 2'b00, 1'b0, 4'd4, 4'd2);
    tick(); expect_v("mw_run", C_NORM, 2'b00, 2'b00, 1'b0, 4'd4, 4'd2);

    // Branch arriving during REDIRECT restarts the redirect.
    tick(); br_taken = 1'b1;
    expect_v("restart_c0", C_BR, 2'b00, 2'b00, 1'b0, 4'd4, 4'd2);
    tick(); expect_v("restart_c1", C_BR, 2'b00, 2'b00, 1'b0, 4'd4, 4'd3);
    tick(); br_taken = 1'b0;
    expect_v("restart_c2", C_RDR, 2'b00, 2'b00, 1'b0, 4'd4, 4'd4);
    tick(); expect_v("restart_run", C_NORM, 2'b00, 2'b00, 1'b0, 4'd4, 4'd4);

    // Non-hazard cases: load to x0, and a matching non-load.
    tick(); q3_mem_re = 1'b1; q3_rd = 5'd0;
    expect_v("lu_x0", C_NORM, 2'b00, 2'b00, 1'b0, 4'd4, 4'd4);
    tick(); q3_mem_re = 1'b0; q3_rd = 5'd9; q2_rs2 = 5'd9;
    expect_v("no_load", C_NORM, 2'b00, 2'b00, 1'b0, 4'd4, 4'd4);

    // Twenty load-use stalls on rs2; the counter saturates at 15.
    for (int i = 0; i < 20; i++) begin
      int s;
      tick(); q3_mem_re = 1'b1; q3_rd = 5'd9; q2_rs2 = 5'd9; q2_rs1 = 5'd1;
      s = 4 + i;
      expect_v("lu_sat", C_LU, 2'b00, 2'b00, 1'b0, 4'((s > 15) ? 15 : s), 4'd4);
    end
    tick(); idle(); expect_v("sat_hold", C_NORM, 2'b00, 2'b00, 1'b0, 4'd15, 4'd4);

    // Reset asserted mid-REDIRECT takes effect immediately.
    tick(); br_taken = 1'b1;
    expect_v("pre_rst_br", C_BR, 2'b00, 2'b00, 1'b0, 4'd15, 4'd4);
    tick(); br_taken = 1'b0; rst_n = 1'b0; q3_rs1 = 5'd7; q4_rd = 5'd7; q4_reg_we = 1'b1;
    expect_v("rst_mid_redir", C_RST, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0);
    tick(); rst_n = 1'b1;
    expect_v("post_rst_run", C_NORM, 2'b10, 2'b00, 1'b0, 4'd0, 4'd0);
    tick(); idle(); expect_v("post_rst_idle", C_NORM, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0);

    // Memory timeout after four busy cycles; fault is sticky.
    for (int i = 0; i < 4; i++) begin
      tick(); mem_busy = 1'b1;
      expect_v("to_wait", C_FRZ, 2'b00, 2'b00, 1'b0, 4'(i), 4'd0);
    end
    tick(); expect_v("to_fault", C_FRZ, 2'b00, 2'b00, 1'b1, 4'd4, 4'd0);
    tick(); mem_busy = 1'b0;
    expect_v("fault_hold", C_FRZ, 2'b00, 2'b00, 1'b1, 4'd4, 4'd0);
    tick(); br_taken = 1'b1; q3_mem_re = 1'b1; q3_rd = 5'd5; q2_rs1 = 5'd5;
    expect_v("fault_ignore", C_FRZ, 2'b00, 2'b00, 1'b1, 4'd4, 4'd0);
    tick(); idle(); rst_n = 1'b0;
    expect_v("fault_rst", C_RST, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0);
    tick(); rst_n = 1'b1;
    expect_v("fault_cleared", C_NORM, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0);

    tick();
    for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
